// File: rtl/vga_timing_generator.sv
// ---------------------------------------------------------------------------
// vga_timing_generator
//
// Purpose:
//   Produces VGA raster timing (default 640x480@60 Hz) from a pixel-rate
//   enable strobe. Horizontal and vertical counters scan the full frame
//   including porches and sync. Active-region coordinates go downstream to
//   the cellular automaton. Sync and blank are delayed by SYNC_DELAY enabled
//   cycles so they line up with the automaton's registered RGB output.
//
// Ports:
//   clock_i          system clock
//   reset_i          asynchronous, active-low reset
//   enable_i         pixel-rate strobe; counters/pipeline advance only when high
//   x_pixel_coord_o  active column, 0 during blanking
//   y_pixel_coord_o  active row, 0 during blanking
//   pixel_valid_o    counters inside the active region (undelayed)
//   frame_start_o    one-clock pulse after the enabled edge that wraps to (0,0)
//   hsync_n_o        horizontal sync, active-low, delayed SYNC_DELAY
//   vsync_n_o        vertical sync, active-low, delayed SYNC_DELAY
//   blank_n_o        high in the active region, delayed SYNC_DELAY
// ---------------------------------------------------------------------------
module vga_timing_generator #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter int SYNC_DELAY = 1
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       enable_i,
   output logic [9:0] x_pixel_coord_o,
   output logic [9:0] y_pixel_coord_o,
   output logic       pixel_valid_o,
   output logic       frame_start_o,
   output logic       hsync_n_o,
   output logic       vsync_n_o,
   output logic       blank_n_o
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FRONT);
   localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FRONT);
   localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);

   logic [9:0] h_count_q, h_count_d;
   logic [9:0] v_count_q, v_count_d;
   logic       frame_start_q, frame_start_d;
   logic       active;
   logic       hsync_raw_n;
   logic       vsync_raw_n;
   logic       blank_raw_n;

   // Raster counters; frame_start is armed only by the edge that wraps both
   // counters, so leaving reset at (0,0) does not produce a pulse.
   always_comb begin
      h_count_d     = h_count_q;
      v_count_d     = v_count_q;
      frame_start_d = 1'b0;
      if (enable_i) begin
         if (h_count_q == H_LAST) begin
            h_count_d = 10'd0;
            if (v_count_q == V_LAST) begin
               v_count_d     = 10'd0;
               frame_start_d = 1'b1;
            end else begin
               v_count_d = v_count_q + 10'd1;
            end
         end else begin
            h_count_d = h_count_q + 10'd1;
         end
      end
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         h_count_q     <= 10'd0;
         v_count_q     <= 10'd0;
         frame_start_q <= 1'b0;
      end else begin
         h_count_q     <= h_count_d;
         v_count_q     <= v_count_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign active          = (h_count_q < H_ACT) && (v_count_q < V_ACT);
   assign pixel_valid_o   = active;
   assign x_pixel_coord_o = active ? h_count_q : 10'd0;
   assign y_pixel_coord_o = active ? v_count_q : 10'd0;
   assign frame_start_o   = frame_start_q;

   // Vertical sync depends only on the line number, so it covers whole lines.
   assign hsync_raw_n = !((h_count_q >= HS_START) && (h_count_q <= HS_END));
   assign vsync_raw_n = !((v_count_q >= VS_START) && (v_count_q <= VS_END));
   assign blank_raw_n = active;

   generate
      if (SYNC_DELAY == 0) begin : g_no_delay
         assign hsync_n_o = hsync_raw_n;
         assign vsync_n_o = vsync_raw_n;
         assign blank_n_o = blank_raw_n;
      end else begin : g_delay
         logic [SYNC_DELAY-1:0] hsync_pipe_q, hsync_pipe_d;
         logic [SYNC_DELAY-1:0] vsync_pipe_q, vsync_pipe_d;
         logic [SYNC_DELAY-1:0] blank_pipe_q, blank_pipe_d;

         // Stage 0 takes the raw decode; later stages shift on enabled cycles.
         always_comb begin
            hsync_pipe_d = hsync_pipe_q;
            vsync_pipe_d = vsync_pipe_q;
            blank_pipe_d = blank_pipe_q;
            if (enable_i) begin
               hsync_pipe_d[0] = hsync_raw_n;
               vsync_pipe_d[0] = vsync_raw_n;
               blank_pipe_d[0] = blank_raw_n;
               for (int i = 1; i < SYNC_DELAY; i++) begin
                  hsync_pipe_d[i] = hsync_pipe_q[i-1];
                  vsync_pipe_d[i] = vsync_pipe_q[i-1];
                  blank_pipe_d[i] = blank_pipe_q[i-1];
               end
            end
         end

         always_ff @(posedge clock_i or negedge reset_i) begin
            if (!reset_i) begin
               hsync_pipe_q <= '1;
               vsync_pipe_q <= '1;
               blank_pipe_q <= '0;
            end else begin
               hsync_pipe_q <= hsync_pipe_d;
               vsync_pipe_q <= vsync_pipe_d;
               blank_pipe_q <= blank_pipe_d;
            end
         end

         assign hsync_n_o = hsync_pipe_q[SYNC_DELAY-1];
         assign vsync_n_o = vsync_pipe_q[SYNC_DELAY-1];
         assign blank_n_o = blank_pipe_q[SYNC_DELAY-1];
      end
   endgenerate

endmodule

// File: tb/tb_vga_timing_generator.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_generator
//
// Drives two instances of the timing generator (SYNC_DELAY=1 and SYNC_DELAY=0)
// with a shrunken raster so whole frames fit in a short run. A position-based
// model tracks the raster coordinate and derives every output from the
// timing rules directly.
// ---------------------------------------------------------------------------
module tb_vga_timing_generator;

   localparam int HA = 20;
   localparam int HF = 4;
   localparam int HS = 6;
   localparam int HB = 5;
   localparam int VA = 12;
   localparam int VF = 2;
   localparam int VS = 2;
   localparam int VB = 3;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;

   logic       clock_i  = 1'b0;
   logic       reset_i  = 1'b0;
   logic       enable_i = 1'b0;

   logic [9:0] d1_x, d1_y, d0_x, d0_y;
   logic       d1_valid, d1_fs, d1_hs, d1_vs, d1_blank;
   logic       d0_valid, d0_fs, d0_hs, d0_vs, d0_blank;

   int errors = 0;
   int checks = 0;

   // Model state: current raster position plus the one-enabled-cycle-old
   // sync/blank values seen by the delayed instance.
   int mh = 0;
   int mv = 0;
   bit e_hs1 = 1'b1;
   bit e_vs1 = 1'b1;
   bit e_bl1 = 1'b0;
   bit e_fs  = 1'b0;

   always #5 clock_i = ~clock_i;

   vga_timing_generator #(
      .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .SYNC_DELAY(1)
   ) dut_d1 (
      .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i),
      .x_pixel_coord_o(d1_x), .y_pixel_coord_o(d1_y),
      .pixel_valid_o(d1_valid), .frame_start_o(d1_fs),
      .hsync_n_o(d1_hs), .vsync_n_o(d1_vs), .blank_n_o(d1_blank)
   );

   vga_timing_generator #(
      .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .SYNC_DELAY(0)
   ) dut_d0 (
      .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i),
      .x_pixel_coord_o(d0_x), .y_pixel_coord_o(d0_y),
      .pixel_valid_o(d0_valid), .frame_start_o(d0_fs),
      .hsync_n_o(d0_hs), .vsync_n_o(d0_vs), .blank_n_o(d0_blank)
   );

   function automatic bit isActive(input int h, input int v);
      return (h < HA) && (v < VA);
   endfunction

   function automatic bit hsyncN(input int h);
      return !((h >= HA + HF) && (h < HA + HF + HS));
   endfunction

   function automatic bit vsyncN(input int v);
      return !((v >= VA + VF) && (v < VA + VF + VS));
   endfunction

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      mh    = 0;
      mv    = 0;
      e_hs1 = 1'b1;
      e_vs1 = 1'b1;
      e_bl1 = 1'b0;
      e_fs  = 1'b0;
   endtask

   // Set inputs, take one clock edge, then move the model by the same rules.
   task automatic applyStimulus(input bit en, input bit rst);
      enable_i = en;
      reset_i  = rst;
      @(posedge clock_i);
      #1;
      if (!rst) begin
         modelReset();
      end else if (en) begin
         e_hs1 = hsyncN(mh);
         e_vs1 = vsyncN(mv);
         e_bl1 = isActive(mh, mv);
         mh = mh + 1;
         if (mh == HT) begin
            mh = 0;
            mv = (mv + 1) % VT;
         end
         e_fs = (mh == 0) && (mv == 0);
      end else begin
         e_fs = 1'b0;
      end
   endtask

   task automatic checkOutput();
      bit act;
      act = isActive(mh, mv);
      check("d1_x",     d1_x,     act ? mh : 0);
      check("d1_y",     d1_y,     act ? mv : 0);
      check("d1_valid", d1_valid, act);
      check("d1_fs",    d1_fs,    e_fs);
      check("d1_hs",    d1_hs,    e_hs1);
      check("d1_vs",    d1_vs,    e_vs1);
      check("d1_blank", d1_blank, e_bl1);
      check("d0_x",     d0_x,     act ? mh : 0);
      check("d0_y",     d0_y,     act ? mv : 0);
      check("d0_valid", d0_valid, act);
      check("d0_fs",    d0_fs,    e_fs);
      check("d0_hs",    d0_hs,    hsyncN(mh));
      check("d0_vs",    d0_vs,    vsyncN(mv));
      check("d0_blank", d0_blank, act);
      check("d0_blank_eq_valid", d0_blank, d0_valid);
   endtask

   initial begin
      int vsLow;
      int fsCount;
      bit prevHs;
      int lastFall;
      int period;
      int run;
      int pulse;
      bit found;

      $display("[TB] start");

      // Reset held for three clocks.
      repeat (3) begin
         applyStimulus(1'b0, 1'b0);
         checkOutput();
      end
      check("rst_hs", d1_hs, 1);
      check("rst_vs", d1_vs, 1);
      check("rst_blank", d1_blank, 0);
      check("rst_x", d1_x, 0);
      check("rst_y", d1_y, 0);
      check("rst_fs", d1_fs, 0);

      // Release with continuous enable: first edge moves to column 1.
      applyStimulus(1'b1, 1'b1);
      checkOutput();
      check("first_x", d1_x, 1);

      // One full frame of continuous enable.
      vsLow   = 0;
      fsCount = 0;
      repeat (HT * VT) begin
         applyStimulus(1'b1, 1'b1);
         checkOutput();
         if (!d1_vs) vsLow++;
         if (d1_fs) fsCount++;
      end
      check("frame_vsync_low", vsLow, VS * HT);
      check("frame_start_count", fsCount, 1);

      // Enable toggling every clock: periods double in clock units.
      prevHs   = d1_hs;
      lastFall = -1;
      period   = -1;
      run      = 0;
      pulse    = -1;
      for (int c = 0; c < 2 * HT * VT; c++) begin
         applyStimulus((c % 2) == 0, 1'b1);
         checkOutput();
         if (prevHs && !d1_hs) begin
            if (lastFall >= 0) period = c - lastFall;
            lastFall = c;
            run = 0;
         end
         if (!d1_hs) run++;
         if (!prevHs && d1_hs) pulse = run;
         prevHs = d1_hs;
      end
      check("toggle_line_period", period, 2 * HT);
      check("toggle_hsync_width", pulse, 2 * HS);

      // Random enable pattern.
      repeat (2000) begin
         applyStimulus(1'(($urandom % 2)), 1'b1);
         checkOutput();
      end

      // Reach an active pixel mid-frame, then assert reset between edges.
      found = 1'b0;
      for (int c = 0; c < 2 * HT * VT && !found; c++) begin
         applyStimulus(1'b1, 1'b1);
         checkOutput();
         if (mh == 10 && mv == 5) found = 1'b1;
      end
      check("reach_target", found, 1);
      #2;
      reset_i = 1'b0;
      #1;
      check("async_hs", d1_hs, 1);
      check("async_vs", d1_vs, 1);
      check("async_blank", d1_blank, 0);
      check("async_x", d1_x, 0);
      check("async_y", d1_y, 0);
      check("async_fs", d1_fs, 0);
      modelReset();
      repeat (2) begin
         applyStimulus(1'b1, 1'b0);
         checkOutput();
      end
      reset_i = 1'b1;
      #1;
      check("restart_x0", d1_x, 0);
      check("restart_y0", d1_y, 0);
      check("restart_valid", d1_valid, 1);
      applyStimulus(1'b1, 1'b1);
      checkOutput();
      check("restart_x1", d1_x, 1);
      repeat (300) begin
         applyStimulus(1'(($urandom % 2)), 1'b1);
         checkOutput();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
- Upstream stage of cellular_automaton. Generates 640x480@60 Hz VGA raster timing from the pixel-rate enable.
- Drives x_pixel_coord/y_pixel_coord into the automaton and produces hsync, vsync and blank toward the VGA DAC.
- Sync and blank are delayed by a configurable pipeline so they stay aligned with the automaton's registered RGB output.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_DELAY, 1, pipeline depth applied to hsync/vsync/blank; range 0..4

Ports:
- clock_i  input  1  system clock
- reset_i  input  1  asynchronous, active-low reset
- enable_i  input  1  pixel-rate strobe; counters advance only when high
- x_pixel_coord_o  output  10  active column 0..639; 0 during blanking
- y_pixel_coord_o  output  10  active row 0..479; 0 during blanking
- pixel_valid_o  output  1  high when the current counters are inside the active region (undelayed)
- frame_start_o  output  1  one-cycle pulse on the enabled cycle where h_count=0 and v_count=0
- hsync_n_o  output  1  horizontal sync, active-low, delayed SYNC_DELAY enabled cycles
- vsync_n_o  output  1  vertical sync, active-low, delayed SYNC_DELAY enabled cycles
- blank_n_o  output  1  high in the active region, delayed SYNC_DELAY enabled cycles

Behaviour:
- Derived totals: H_TOTAL=H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL=V_ACTIVE+V_FRONT+V_SYNC+V_BACK (525).
- Internal h_count is 10 bits, 0..H_TOTAL-1. v_count is 10 bits, 0..V_TOTAL-1.
- Reset (reset_i=0, asynchronous):
  - h_count=0, v_count=0.
  - All delay-pipeline stages load their inactive values: hsync_n=1, vsync_n=1, blank_n=0.
  - frame_start_o=0.
- Reset release: the first enabled cycle presents pixel (0,0).
- On a rising edge with enable_i=1:
  - If h_count==H_TOTAL-1: h_count wraps to 0 and v_count advances (wraps to 0 at V_TOTAL-1).
  - Otherwise h_count increments.
- enable_i=0: all counters and pipeline stages hold. Outputs are stable. frame_start_o=0.
- Active region: h_count<H_ACTIVE and v_count<V_ACTIVE.
- Combinational from the counter registers (0-cycle latency):
  - pixel_valid_o = active region.
  - x_pixel_coord_o = active ? h_count : 0.
  - y_pixel_coord_o = active ? v_count : 0.
- Raw sync and blank terms:
  - hsync raw low for h_count in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1], i.e. [656,751].
  - vsync raw low for v_count in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1], i.e. [490,491], for the entire line.
  - blank raw = active region.
- Delay pipeline: the raw terms pass through a SYNC_DELAY-stage shift register clocked only on enabled cycles.
  - SYNC_DELAY=0 gives a combinational pass-through.
  - Pipeline stages are reset exactly like the outputs.
- frame_start_o is registered: it is high for the single clock after the enabled edge that moved the counters to (0,0).
  - After reset it fires only on the first frame wrap, not on reset release.
- Simultaneous end of line and end of frame (h=799, v=524): both counters wrap to 0 on the same edge.
- Reset asserted mid-frame: counters return to 0 immediately. Outputs go to reset values without waiting for a clock.
- No parameter validity checking; behaviour with totals over 1023 is undefined.

Test Plan:
- Reset held 3 cycles, then enable_i=1 continuously:
  - During reset: hsync_n_o=1, vsync_n_o=1, blank_n_o=0, x=0, y=0.
  - First enabled edge after release: x_pixel_coord_o=1.
- enable_i toggled 1/0 each cycle (50 MHz-to-25 MHz case):
  - Counters advance only on enabled edges.
  - Line period = 1600 clocks; hsync_n_o low for 192 clocks.
- SYNC_DELAY=1, free-running:
  - x reaches 639 then shows 0 for 160 pixels.
  - blank_n_o falls one enabled cycle after pixel_valid_o falls.
  - hsync_n_o falls one enabled cycle after h_count=656.
- Run one full frame (420000 enabled cycles):
  - vsync_n_o low for exactly 1600 enabled cycles, starting one cycle after line 490.
  - frame_start_o pulses exactly once, at wrap to (0,0).
- Assert reset_i=0 asynchronously at h=300, v=200:
  - Within the same cycle, outputs return to reset values.
  - After release, counting restarts at (0,0).
- SYNC_DELAY=0:
  - hsync_n_o, vsync_n_o and blank_n_o track the raw decode in the same cycle as the counters.
  - blank_n_o equals pixel_valid_o at every cycle.
